// File: rtl/sdram_copy_pkg.sv
// -----------------------------------------------------------------------------
// sdram_copy_pkg
// Shared definitions for the SDRAM word-copy engine:
//   state_e   - copy FSM states (IDLE / RUN / DONE)
//   ADDR_STEP - default byte increment between consecutive words
// -----------------------------------------------------------------------------
package sdram_copy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/sdram_copy_engine_if.sv
// -----------------------------------------------------------------------------
// sdram_copy_engine_if
// Avalon-MM pipelined master bus between the copy engine and SDRAM.
//   waitrequest   - slave stall; a presented command is held while high
//   address       - byte address of the current command
//   read / write  - command strobes (at most one high at a time)
//   readdata      - read response data, qualified by readdatavalid
//   readdatavalid - one pulse per returned read word, in issue order
//   writedata     - data for the current write command
// Modports: master (copy engine side), slave (memory / bus model side).
// -----------------------------------------------------------------------------
interface sdram_copy_engine_if;

    logic        waitrequest;
    logic [31:0] address;
    logic        read;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        write;
    logic [31:0] writedata;

    modport master (
        input  waitrequest, readdata, readdatavalid,
        output address, read, write, writedata
    );

    modport slave (
        output waitrequest, readdata, readdatavalid,
        input  address, read, write, writedata
    );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock in-order FIFO with a combinational head (dout shows the oldest
// entry whenever empty=0). Push and pop in the same cycle leave count unchanged.
//   clk, rst_n - clock, synchronous active-low reset (clears pointers/count)
//   push, din  - write din at the tail
//   pop        - drop the head entry (caller only pops when not empty)
//   dout       - head entry
//   count      - number of stored entries (0..DEPTH)
//   full/empty - count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: the storage array is deliberately not reset; pointers and count
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/sdram_copy_engine.sv
// -----------------------------------------------------------------------------
// sdram_copy_engine
// Copies num_words 32-bit words from src_addr to dest_addr over one Avalon-MM
// pipelined master port. Reads are issued ahead into a small FIFO (bounded by
// a read credit) and drained as writes in source order.
//   clk, rst_n            - clock, synchronous active-low reset
//   dest_addr, src_addr   - byte addresses, sampled when an enable is accepted
//   num_words             - word count, sampled when an enable is accepted
//   enable                - one-cycle start pulse (ignored unless IDLE)
//   copying               - high while a job is in progress
//   bus                   - Avalon-MM master port (sdram_copy_engine_if.master)
// -----------------------------------------------------------------------------
module sdram_copy_engine
    import sdram_copy_pkg::state_e;
    import sdram_copy_pkg::IDLE;
    import sdram_copy_pkg::RUN;
    import sdram_copy_pkg::DONE;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_STEP  = sdram_copy_pkg::ADDR_STEP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                dest_addr,
    input  logic [31:0]                src_addr,
    input  logic [31:0]                num_words,
    input  logic                       enable,
    output logic                       copying,
    sdram_copy_engine_if.master        bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e      state_q;
    logic [31:0] dest_q, src_q, num_q;
    logic [31:0] rd_issued_q, wr_issued_q, rd_out_q;
    logic [31:0] addr_q, wdata_q;
    logic        read_q, write_q, copying_q;

    logic [31:0]      fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic running, cmd_accept, cmd_free, credit_ok;
    logic sel_write, sel_read, last_write;

    // NOTE: every signal gets its value on every path through this block, so
    // no latch can be inferred.
    always_comb begin
        running    = (state_q == RUN);
        cmd_accept = (read_q | write_q) & ~bus.waitrequest;
        // A new command may be chosen only when the bus slot is empty or the
        // pending command is being accepted this cycle.
        cmd_free   = ~(read_q | write_q) | cmd_accept;
        // Reads are counted outstanding from selection, so the pending read
        // already holds its FIFO slot while it waits out a stall.
        credit_ok  = (rd_out_q + 32'(fifo_count)) < 32'(FIFO_DEPTH);
        // wr_issued_q counts writes from selection, so it equals num_q while
        // the final write is on the bus.
        last_write = write_q & cmd_accept & (wr_issued_q == num_q);
        sel_write  = running & cmd_free & ~fifo_empty;
        sel_read   = running & cmd_free & fifo_empty & (rd_issued_q < num_q) & credit_ok;
        fifo_push  = running & bus.readdatavalid;
        // The head word moves into the write-data register when the write is chosen.
        fifo_pop   = sel_write;
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.readdata),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dest_q      <= '0;
            src_q       <= '0;
            num_q       <= '0;
            rd_issued_q <= '0;
            wr_issued_q <= '0;
            rd_out_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            copying_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    if (enable) begin
                        dest_q      <= dest_addr;
                        src_q       <= src_addr;
                        num_q       <= num_words;
                        rd_issued_q <= '0;
                        wr_issued_q <= '0;
                        rd_out_q    <= '0;
                        copying_q   <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    rd_out_q <= rd_out_q + 32'(sel_read) - 32'(fifo_push);
                    if ((num_q == '0) || last_write) begin
                        read_q    <= 1'b0;
                        write_q   <= 1'b0;
                        copying_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (sel_write) begin
                        write_q     <= 1'b1;
                        read_q      <= 1'b0;
                        addr_q      <= dest_q + ADDR_STEP * wr_issued_q;
                        wdata_q     <= fifo_dout;
                        wr_issued_q <= wr_issued_q + 32'd1;
                    end else if (sel_read) begin
                        read_q      <= 1'b1;
                        write_q     <= 1'b0;
                        addr_q      <= src_q + ADDR_STEP * rd_issued_q;
                        rd_issued_q <= rd_issued_q + 32'd1;
                    end else if (cmd_accept) begin
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                DONE: begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign copying       = copying_q;
    assign bus.address   = addr_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.writedata = wdata_q;

    // A push into a full FIFO without a pop would mean the read credit is wrong.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_sdram_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_sdram_copy_engine
// Self-checking bench: an Avalon slave model answers reads with a known data
// pattern after a programmable latency and can stall chosen commands; expected
// read addresses and write address/data pairs are queued when each job starts
// and compared as the engine's commands are accepted.
// -----------------------------------------------------------------------------
module tb_sdram_copy_engine;

    localparam int STALL_LEN = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dest_addr = '0;
    logic [31:0] src_addr = '0;
    logic [31:0] num_words = '0;
    logic        enable = 1'b0;
    logic        copying;

    sdram_copy_engine_if bus ();

    sdram_copy_engine #(
        .FIFO_DEPTH (4),
        .ADDR_STEP  (32'd4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dest_addr (dest_addr),
        .src_addr  (src_addr),
        .num_words (num_words),
        .enable    (enable),
        .copying   (copying),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int due; logic [31:0] data; } resp_t;

    logic [31:0] exp_rq [$];
    wr_t         exp_wq [$];
    resp_t       resp_q [$];

    int checks = 0;
    int errors = 0;

    int cyc = 0, lat = 2, stall_rd_idx = -1, stall_wr_idx = -1;
    int rd_stall_cnt = 0, wr_stall_cnt = 0, rd_acc = 0, wr_acc = 0, wr_started = 0;
    int inflight = 0, max_inflight = 0, last_wr_cyc = 0, fall_cyc = 0;
    int copy_hi = 0, reads_seen = 0, writes_seen = 0;
    bit job_done = 1'b0, stalled = 1'b0, copying_prev = 1'b0, hold = 1'b0;
    logic [1:0]  saved_strb = '0;
    logic [31:0] saved_addr = '0, saved_wdata = '0;
    wr_t         w_exp;
    resp_t       r_cur, r_new;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Source memory contents: a fixed function of the byte address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Slave model and monitor: works on the falling edge, where the engine's
    // registered outputs are stable, and drives the inputs for the next edge.
    initial begin
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("stall_strobe", {30'd0, bus.read, bus.write}, {30'd0, saved_strb});
                check("stall_addr", bus.address, saved_addr);
                if (saved_strb == 2'b01) check("stall_wdata", bus.writedata, saved_wdata);
            end
            hold = 1'b0;
            if (rst_n && bus.read && rd_acc == stall_rd_idx && rd_stall_cnt < STALL_LEN) begin
                hold = 1'b1;
                rd_stall_cnt++;
            end
            if (rst_n && bus.write && wr_acc == stall_wr_idx && wr_stall_cnt < STALL_LEN) begin
                hold = 1'b1;
                wr_stall_cnt++;
            end
            bus.waitrequest = hold;
            if (rst_n && bus.write && !stalled) wr_started++;
            stalled     = rst_n && (bus.read || bus.write) && hold;
            saved_strb  = {bus.read, bus.write};
            saved_addr  = bus.address;
            saved_wdata = bus.writedata;
            if (rst_n && bus.read && !hold) begin
                check("rd_expected", 32'(exp_rq.size() > 0), 32'd1);
                if (exp_rq.size() > 0) check("rd_addr", bus.address, exp_rq.pop_front());
                r_new.due  = cyc + lat;
                r_new.data = mem_val(bus.address);
                resp_q.push_back(r_new);
                rd_acc++;
            end
            if (rst_n && bus.write && !hold) begin
                check("wr_expected", 32'(exp_wq.size() > 0), 32'd1);
                if (exp_wq.size() > 0) begin
                    w_exp = exp_wq.pop_front();
                    check("wr_addr", bus.address, w_exp.addr);
                    check("wr_data", bus.writedata, w_exp.data);
                end
                wr_acc++;
                last_wr_cyc = cyc;
            end
            inflight = rd_acc - wr_started;
            if (inflight > max_inflight) max_inflight = inflight;
            if (bus.read)  reads_seen++;
            if (bus.write) writes_seen++;
            if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
                r_cur = resp_q.pop_front();
                bus.readdatavalid = 1'b1;
                bus.readdata      = r_cur.data;
            end else begin
                bus.readdatavalid = 1'b0;
                bus.readdata      = $urandom;
            end
            if (copying) copy_hi++;
            if (copying_prev && !copying) begin
                fall_cyc = cyc;
                job_done = 1'b1;
            end
            copying_prev = copying;
        end
    end

    task automatic start_job(input logic [31:0] src, input logic [31:0] dest,
                             input logic [31:0] n, input int latency,
                             input int srd, input int swr);
        logic [31:0] a;
        wr_t         w;
        @(posedge clk); #2;
        lat = latency;
        stall_rd_idx = srd;
        stall_wr_idx = swr;
        rd_stall_cnt = 0;
        wr_stall_cnt = 0;
        rd_acc = 0;
        wr_acc = 0;
        wr_started = 0;
        max_inflight = 0;
        last_wr_cyc = 0;
        fall_cyc = 0;
        job_done = 1'b0;
        for (int i = 0; i < int'(n); i++) begin
            a = src + 32'(i) * 32'd4;
            exp_rq.push_back(a);
            w.addr = dest + 32'(i) * 32'd4;
            w.data = mem_val(a);
            exp_wq.push_back(w);
        end
        src_addr  = src;
        dest_addr = dest;
        num_words = n;
        enable    = 1'b1;
        @(posedge clk); #2;
        enable    = 1'b0;
        src_addr  = $urandom;
        dest_addr = $urandom;
        num_words = $urandom;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && !job_done; i++) @(posedge clk);
        check(tag, 32'(job_done), 32'd1);
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dest,
                           input logic [31:0] n, input int latency,
                           input int srd, input int swr, input bit reenable);
        start_job(src, dest, n, latency, srd, swr);
        if (reenable) begin
            repeat (3) @(posedge clk);
            #2;
            src_addr  = 32'hBAD0_0000;
            dest_addr = 32'hBAD1_0000;
            num_words = 32'd7;
            enable    = 1'b1;
            @(posedge clk); #2;
            enable    = 1'b0;
        end
        wait_done("job_done");
        check("rd_left", 32'(exp_rq.size()), 32'd0);
        check("wr_left", 32'(exp_wq.size()), 32'd0);
        if (n != 0) check("copy_fall", 32'(fall_cyc - last_wr_cyc), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int r0, w0, c0;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_copying", 32'(copying), 32'd0);
        check("rst_read", 32'(bus.read), 32'd0);
        check("rst_write", 32'(bus.write), 32'd0);
        check("rst_addr", bus.address, 32'd0);
        check("rst_wdata", bus.writedata, 32'd0);
        #1 rst_n = 1'b1;

        // Zero-length job: one cycle of copying, no bus traffic.
        r0 = reads_seen; w0 = writes_seen; c0 = copy_hi;
        run_job(32'h0000_0100, 32'h0000_0200, 32'd0, 2, -1, -1, 1'b0);
        check("zero_reads", 32'(reads_seen - r0), 32'd0);
        check("zero_writes", 32'(writes_seen - w0), 32'd0);
        check("zero_copy_hi", 32'(copy_hi - c0), 32'd1);

        // Basic three-word copy, latency 2.
        run_job(32'h0000_1000, 32'h0000_2000, 32'd3, 2, -1, -1, 1'b0);

        // Long latency: read credit must cap in-flight words at FIFO_DEPTH.
        run_job(32'h0001_0000, 32'h0002_0000, 32'd16, 8, -1, -1, 1'b0);
        check("inflight_max", 32'(max_inflight), 32'd4);

        // Stalls on the 2nd read and 1st write; a stray enable mid-job is ignored.
        run_job(32'h0000_8000, 32'h0000_9000, 32'd4, 2, 1, 0, 1'b1);

        // Source address wraps past the top of the address space.
        run_job(32'hFFFF_FFF8, 32'h0000_3000, 32'd3, 3, -1, -1, 1'b0);

        // Reset mid-job, then a fresh two-word job after stale responses drain.
        start_job(32'h0000_4000, 32'h0000_5000, 32'd10, 6, -1, -1);
        for (int i = 0; i < 3000 && wr_acc < 5; i++) @(posedge clk);
        check("mid_reached", 32'(wr_acc >= 5), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_read", 32'(bus.read), 32'd0);
        check("abort_write", 32'(bus.write), 32'd0);
        check("abort_copying", 32'(copying), 32'd0);
        check("abort_addr", bus.address, 32'd0);
        #1;
        rst_n = 1'b1;
        exp_rq.delete();
        exp_wq.delete();
        repeat (10) @(posedge clk);
        run_job(32'h0000_6000, 32'h0000_7000, 32'd2, 3, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
